// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared types for the parking barrier lane controller
package parking_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRANT = 3'd1,
        OPEN  = 3'd2,
        HOLD  = 3'd3,
        CLOSE = 3'd4
    } state_t;

    typedef enum logic {
        DIR_ENTRY = 1'b0,
        DIR_EXIT  = 1'b1
    } dir_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gate_timer.sv
// rtl/gate_timer.sv - shared up-counter with clear/enable and terminal-count compare
module gate_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clear,
    input  logic         i_enable,
    input  logic [W-1:0] i_terminal,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = (r_count == i_terminal);

endmodule

// File: rtl/parking_gate_ctrl.sv
// rtl/parking_gate_ctrl.sv - barrier lane FSM, entry/exit arbiter and occupancy count
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int TOTAL_SPOTS  = 15,
    parameter int CNT_W        = 4,
    parameter int PASS_TIMEOUT = 64,
    parameter int HOLD_CYCLES  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic             pass_sensor,
    output logic             barrier_open,
    output logic             grant_entry,
    output logic             grant_exit,
    output logic [CNT_W-1:0] occupied,
    output logic [CNT_W-1:0] spots,
    output logic             full,
    output logic             busy,
    output logic             timeout_err
);

    localparam int TMR_MAX = max_int(PASS_TIMEOUT, HOLD_CYCLES);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] LP_OPEN_TC = TMR_W'(PASS_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] LP_HOLD_TC = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_TOTAL   = CNT_W'(TOTAL_SPOTS);

    state_t           r_state;
    state_t           w_next_state;
    // Serves both as the latched direction of the current cycle and as the
    // round-robin pointer; reset to ENTRY so that exit wins the first tie.
    dir_t             r_dir;
    dir_t             w_winner;
    logic             r_pass_q;
    logic             r_timeout_err;
    logic [CNT_W-1:0] r_occupied;
    logic [CNT_W-1:0] r_spots;
    logic             r_full;

    logic             w_entry_elig;
    logic             w_exit_elig;
    logic             w_pass_rise;
    logic             w_clear;
    logic             w_enable;
    logic             w_tc;
    logic [TMR_W-1:0] w_terminal;
    logic             w_occ_inc;
    logic             w_occ_dec;
    logic             w_timeout;
    logic [CNT_W-1:0] w_occ_next;

    assign w_entry_elig = entry_req && !r_full;
    assign w_exit_elig  = exit_req && (r_occupied != '0);
    assign w_pass_rise  = pass_sensor && !r_pass_q;
    assign w_terminal   = (r_state == HOLD) ? LP_HOLD_TC : LP_OPEN_TC;

    assign w_winner = (w_entry_elig && w_exit_elig) ?
                          ((r_dir == DIR_ENTRY) ? DIR_EXIT : DIR_ENTRY) :
                      (w_exit_elig ? DIR_EXIT : DIR_ENTRY);

    gate_timer #(
        .W (TMR_W)
    ) u_gate_timer (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_clear),
        .i_enable   (w_enable),
        .i_terminal (w_terminal),
        .o_tc       (w_tc)
    );

    always_comb begin
        w_next_state = r_state;
        w_clear      = 1'b0;
        w_enable     = 1'b0;
        w_occ_inc    = 1'b0;
        w_occ_dec    = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_entry_elig || w_exit_elig) begin
                    w_next_state = GRANT;
                end
            end
            GRANT: begin
                w_next_state = OPEN;
                w_clear      = 1'b1;
            end
            OPEN: begin
                if (w_pass_rise) begin
                    w_next_state = HOLD;
                    w_clear      = 1'b1;
                    w_occ_inc    = (r_dir == DIR_ENTRY);
                    w_occ_dec    = (r_dir == DIR_EXIT);
                end else if (w_tc) begin
                    w_next_state = CLOSE;
                    w_timeout    = 1'b1;
                end else begin
                    w_enable = 1'b1;
                end
            end
            HOLD: begin
                // A car still under the barrier restarts the hold window.
                if (pass_sensor) begin
                    w_clear = 1'b1;
                end else if (w_tc) begin
                    w_next_state = CLOSE;
                end else begin
                    w_enable = 1'b1;
                end
            end
            CLOSE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign w_occ_next = w_occ_inc ? (r_occupied + 1'b1) :
                        w_occ_dec ? (r_occupied - 1'b1) : r_occupied;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_dir         <= DIR_ENTRY;
            r_pass_q      <= 1'b0;
            r_timeout_err <= 1'b0;
            r_occupied    <= '0;
            r_spots       <= LP_TOTAL;
            r_full        <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_timeout_err <= w_timeout;
            // Cleared while in GRANT so a sensor already high at OPEN entry
            // is seen as a fresh rising edge.
            r_pass_q      <= (r_state == GRANT) ? 1'b0 : pass_sensor;
            if (r_state == IDLE && w_next_state == GRANT) begin
                r_dir <= w_winner;
            end
            if (w_occ_inc || w_occ_dec) begin
                r_occupied <= w_occ_next;
                r_spots    <= LP_TOTAL - w_occ_next;
                r_full     <= (w_occ_next == LP_TOTAL);
            end
        end
    end

    assign barrier_open = (r_state == OPEN) || (r_state == HOLD);
    assign grant_entry  = (r_state == GRANT) && (r_dir == DIR_ENTRY);
    assign grant_exit   = (r_state == GRANT) && (r_dir == DIR_EXIT);
    assign busy         = (r_state != IDLE);
    assign timeout_err  = r_timeout_err;
    assign occupied     = r_occupied;
    assign spots        = r_spots;
    assign full         = r_full;

    a_occ_bound: assert property (@(posedge clk) disable iff (!reset)
                                  r_occupied <= LP_TOTAL);

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// tb/tb_parking_gate_ctrl.sv - self-checking bench for parking_gate_ctrl
module tb_parking_gate_ctrl;

    localparam int TOTAL = 15;
    localparam int HOLD  = 8;
    localparam int TMO   = 64;
    localparam int G_NONE  = 0;
    localparam int G_ENTRY = 1;
    localparam int G_EXIT  = 2;

    typedef struct {
        logic e;
        logic x;
        int   p1;
        int   gap;
        int   p2;
        int   exp_g;
        int   exp_occ;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       entry_req = 1'b0;
    logic       exit_req = 1'b0;
    logic       pass_sensor = 1'b0;
    logic       barrier_open;
    logic       grant_entry;
    logic       grant_exit;
    logic [3:0] occupied;
    logic [3:0] spots;
    logic       full;
    logic       busy;
    logic       timeout_err;

    int   n_vec = 0;
    int   n_err = 0;
    int   exp_q[$];
    vec_t vecs[$];
    int   mon_g;

    parking_gate_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .entry_req    (entry_req),
        .exit_req     (exit_req),
        .pass_sensor  (pass_sensor),
        .barrier_open (barrier_open),
        .grant_entry  (grant_entry),
        .grant_exit   (grant_exit),
        .occupied     (occupied),
        .spots        (spots),
        .full         (full),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset && (grant_entry || grant_exit)) begin
            if (grant_entry && grant_exit) chk("grant_both", 1, 0);
            mon_g = grant_entry ? G_ENTRY : G_EXIT;
            if (exp_q.size() == 0) chk("grant_unexpected", mon_g, G_NONE);
            else chk("grant_dir", mon_g, exp_q.pop_front());
        end
    end

    task automatic run_vec(input vec_t v);
        int  k;
        int  cnt;
        int  plen;
        bit  seen;
        bit  busy_seen;
        @(posedge clk); #1;
        entry_req = v.e;
        exit_req  = v.x;
        if (v.exp_g == G_NONE) begin
            busy_seen = 0;
            repeat (6) begin
                @(negedge clk);
                if (busy) busy_seen = 1;
            end
            chk("ineligible_busy", busy_seen, 0);
            entry_req = 0;
            exit_req  = 0;
        end else begin
            exp_q.push_back(v.exp_g);
            k = 0;
            seen = 0;
            while (!seen && k < 10) begin
                @(negedge clk);
                k++;
                if (grant_entry || grant_exit) seen = 1;
            end
            chk("grant_seen", seen, 1);
            if (!seen) begin
                void'(exp_q.pop_front());
                entry_req = 0;
                exit_req  = 0;
                return;
            end
            chk("grant_latency", k, 2);
            @(posedge clk); #1;
            entry_req = 0;
            exit_req  = 0;
            @(negedge clk);
            chk("open_after_grant", barrier_open, 1);
            if (v.p1 == 0) begin
                cnt = 1;
                seen = 0;
                for (int c = 0; c < 200 && !seen; c++) begin
                    @(negedge clk);
                    if (timeout_err) begin
                        seen = 1;
                        chk("closed_at_timeout", barrier_open, 0);
                    end else if (barrier_open) begin
                        cnt++;
                    end
                end
                chk("timeout_seen", seen, 1);
                chk("open_cycles_timeout", cnt, TMO);
                @(negedge clk);
                chk("timeout_one_pulse", timeout_err, 0);
            end else begin
                plen = v.p1 + ((v.p2 > 0) ? (v.gap + v.p2) : 0);
                cnt = 0;
                for (int c = 0; c < plen; c++) begin
                    @(posedge clk); #1;
                    pass_sensor = (c < v.p1) || (v.p2 > 0 && c >= v.p1 + v.gap);
                    @(negedge clk);
                    if (barrier_open) cnt++;
                end
                @(posedge clk); #1;
                pass_sensor = 0;
                for (int c = 0; c < 40; c++) begin
                    @(negedge clk);
                    if (!barrier_open) break;
                    cnt++;
                end
                chk("open_cycles_pass", cnt, plen + HOLD);
            end
        end
        for (int c = 0; c < 100 && busy; c++) @(negedge clk);
        chk("idle_return", busy, 0);
        chk("occupied", occupied, v.exp_occ);
        chk("spots", spots, TOTAL - v.exp_occ);
        chk("full", full, (v.exp_occ == TOTAL) ? 1 : 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back('{1'b0, 1'b1, 0, 0, 0, G_NONE, 0});
        vecs.push_back('{1'b1, 1'b0, 3, 0, 0, G_ENTRY, 1});
        for (int i = 2; i <= 5; i++) vecs.push_back('{1'b1, 1'b0, 1, 0, 0, G_ENTRY, i});
        vecs.push_back('{1'b1, 1'b1, 2, 0, 0, G_EXIT, 4});
        vecs.push_back('{1'b1, 1'b1, 2, 0, 0, G_ENTRY, 5});
        vecs.push_back('{1'b1, 1'b1, 1, 0, 0, G_EXIT, 4});
        vecs.push_back('{1'b1, 1'b1, 1, 0, 0, G_ENTRY, 5});
        vecs.push_back('{1'b1, 1'b0, 0, 0, 0, G_ENTRY, 5});
        for (int i = 6; i <= 15; i++) vecs.push_back('{1'b1, 1'b0, 2, 0, 0, G_ENTRY, i});
        vecs.push_back('{1'b1, 1'b0, 0, 0, 0, G_NONE, 15});
        vecs.push_back('{1'b1, 1'b1, 1, 0, 0, G_EXIT, 14});
        vecs.push_back('{1'b1, 1'b0, 1, 0, 0, G_ENTRY, 15});
        vecs.push_back('{1'b0, 1'b1, 2, 3, 2, G_EXIT, 14});

        repeat (3) @(posedge clk);
        #1;
        chk("rst_occupied", occupied, 0);
        chk("rst_spots", spots, TOTAL);
        chk("rst_full", full, 0);
        chk("rst_busy", busy, 0);
        chk("rst_barrier", barrier_open, 0);
        chk("rst_grants", {grant_entry, grant_exit}, 0);
        chk("rst_timeout", timeout_err, 0);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

        @(posedge clk); #1;
        entry_req = 1;
        exp_q.push_back(G_ENTRY);
        for (int c = 0; c < 20 && !barrier_open; c++) @(negedge clk);
        chk("rstopen_barrier_up", barrier_open, 1);
        entry_req = 0;
        @(posedge clk); #3;
        reset = 0;
        #1;
        chk("rstopen_barrier", barrier_open, 0);
        chk("rstopen_busy", busy, 0);
        chk("rstopen_occupied", occupied, 0);
        chk("rstopen_spots", spots, TOTAL);
        chk("rstopen_full", full, 0);
        chk("rstopen_grants", {grant_entry, grant_exit}, 0);
        chk("rstopen_timeout", timeout_err, 0);
        repeat (2) @(negedge clk);
        reset = 1;
        @(negedge clk);

        run_vec('{1'b1, 1'b1, 1, 0, 0, G_ENTRY, 1});

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/parking_gate_ctrl.md
# parking_gate_ctrl

Controller for the single shared barrier lane of the car-park. Arbitrates between the entry and exit request sensors, sequences the barrier through open / hold / close, and owns the occupancy count. The count changes only when a car physically passes the barrier. It sits between the lane sensors and the barrier actuator and feeds `spots` to the availability display.

## Interface
- `TOTAL_SPOTS`, 15: capacity; must be ≤ 2^`CNT_W` − 1.
- `CNT_W`, 4: occupancy counter width.
- `PASS_TIMEOUT`, 64: cycles in OPEN waiting for a pass before abort.
- `HOLD_CYCLES`, 8: cycles the barrier stays open after a pass.

Ports:
- `clk`  input  1  single clock; all logic on rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `entry_req`  input  1  level; car waiting at the entry side.
- `exit_req`  input  1  level; car waiting at the exit side.
- `pass_sensor`  input  1  level; high while a car is under the barrier. Synchronous to `clk`.
- `barrier_open`  output  1  actuator command.
- `grant_entry`  output  1  one-cycle pulse; entry request accepted.
- `grant_exit`  output  1  one-cycle pulse; exit request accepted.
- `occupied`  output  CNT_W  current occupancy.
- `spots`  output  CNT_W  `TOTAL_SPOTS` − `occupied`.
- `full`  output  1  `occupied` == `TOTAL_SPOTS`.
- `busy`  output  1  FSM not in IDLE.
- `timeout_err`  output  1  one-cycle pulse when a grant is aborted.

## Operation
- **Reset values:** state IDLE, `occupied`=0, `spots`=`TOTAL_SPOTS`, `full`=0, `busy`=0, `barrier_open`=0, grants and `timeout_err` = 0, round-robin pointer favouring exit.
- **Eligibility:** entry is eligible if `entry_req` && !`full`. Exit is eligible if `exit_req` && `occupied` > 0.
- **Arbitration (IDLE only):**
  - One eligible requester: it wins.
  - Both eligible: round-robin. The winner is the side opposite the last granted direction. The last granted direction is stored and updated at every grant.
- **FSM states:**
  - IDLE → GRANT when any requester is eligible.
  - GRANT: lasts 1 cycle. Pulse the winner's grant, latch the direction, go to OPEN.
  - OPEN: `barrier_open`=1, timer counts up.
    - Rising edge of `pass_sensor` → HOLD, and update `occupied` (+1 for entry, −1 for exit).
    - Timer reaches `PASS_TIMEOUT` with no edge → CLOSE, pulse `timeout_err`, count unchanged.
  - HOLD: `barrier_open`=1. Remain while `pass_sensor` is high. Once low, count `HOLD_CYCLES` cycles, then → CLOSE. If `pass_sensor` reasserts, restart the hold count. No further count update.
  - CLOSE: lasts 1 cycle, `barrier_open`=0, → IDLE.
- **Rising-edge detection:** uses a registered copy of `pass_sensor`. The registered copy is cleared on entry to OPEN, so a sensor already high at OPEN entry counts as an edge one cycle later.
- **Requests outside IDLE** are ignored (not queued). Requesters must hold the level until granted.
- **Counter saturation:** the counter never wraps. Eligibility gating guarantees this; an assertion checks `occupied` ≤ `TOTAL_SPOTS`.
- **Mid-operation reset:** async return to reset values. The barrier closes immediately and no count update occurs.

## Timing
- Eligible request sampled in IDLE at edge N: grant pulse during cycle N+1; `barrier_open` high from N+2.
- `pass_sensor` rising at edge M in OPEN: `occupied`/`spots`/`full` update after edge M+1.
- Hold: barrier open for `HOLD_CYCLES` cycles after `pass_sensor` falls, then 1 cycle of CLOSE, then IDLE. Minimum gap between successive grants: 3 cycles.
- Timeout: `timeout_err` is pulsed in the cycle CLOSE is entered, `PASS_TIMEOUT` cycles after OPEN entry.
- `spots` and `full` are registered, updated in the same cycle as `occupied`.

## Structure
- **Package `parking_pkg`:** state enum (IDLE, GRANT, OPEN, HOLD, CLOSE) and direction enum (DIR_ENTRY, DIR_EXIT).
- **Sub-module `gate_timer`:** one shared up-counter with `clear`/`enable` and a terminal-count compare. It is reused for both the OPEN timeout and the HOLD count, with width sized to max(`PASS_TIMEOUT`, `HOLD_CYCLES`).
- The FSM, arbiter and occupancy register live in the top module.

## Test plan
- **Reset, then a single entry:** `entry_req`=1, pulse `pass_sensor` for 3 cycles. Expect `grant_entry` pulse, `barrier_open` for 3+8 cycles, `occupied`=1, `spots`=14.
- **Simultaneous requests from reset:** `entry_req`=`exit_req`=1 with `occupied`=5. Exit is granted first (`occupied`=4), then entry on the next round (`occupied`=5).
- **Full lot:** fill to 15; `full`=1, `spots`=0. `entry_req` alone gets no grant and `busy` stays 0. An `exit_req` is still served (`occupied`=14, `full`=0).
- **Timeout:** grant an entry, never assert `pass_sensor`. After 64 cycles in OPEN expect a `timeout_err` pulse, barrier closed, `occupied` unchanged.
- **Empty lot:** `exit_req` with `occupied`=0 gets no grant. Also: `pass_sensor` reasserting in HOLD restarts the 8-cycle hold, with a single count update.
- **Async reset during OPEN:** `barrier_open` drops to 0 immediately; all outputs return to reset values.
